integration_sequencer: RTL

- Controls the trapezoidal altitude integrator that accumulates velocity samples every sample period.
- Issues a periodic sample strobe and an integrator clear pulse.
- Asserts the integrator enable only after the two-sample pipeline is primed, and only for a commanded number of samples.
- Sits between the host command interface and the integrator; it does no arithmetic on sample data.

---
 rtl/integration_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/integration_sequencer.sv
// integration_sequencer
//   Sequencer for the trapezoidal altitude integrator. It produces the periodic
//   sample strobe, a one-cycle integrator clear at the start of each run, and
//   an integrator enable for each accepted sample interval once the two-sample
//   pipeline has been primed. It never touches the sample data itself.
//
//   Optional build macro: INTEG_STALL_TIMEOUT_EN
//     If defined, TIMEOUT consecutive strobes without a valid sample in PRIME
//     or RUN move the sequencer to FAULT, which is left only by reset or
//     cmd_start. If not defined, missing samples simply wait and fault is 0.
//
//   Ports
//     clk               in   system clock
//     reset             in   synchronous, active-high reset
//     cmd_start         in   pulse, begins a run (ignored while busy)
//     cmd_stop          in   pulse, ends a run early
//     cmd_hold          in   level, freezes integration while high
//     run_length[CW]    in   intervals per run, captured on cmd_start
//     sample_valid      in   upstream sample present this clock
//     sample_tick       out  strobe every PERIOD clocks in PRIME/RUN
//     clear_integrator  out  one-cycle accumulator clear
//     start_integration out  integrator enable, one cycle per interval
//     busy              out  high in PRIME, RUN or HOLD
//     done              out  high in DONE
//     fault             out  high in FAULT (optional feature only)
//     sample_count[CW]  out  intervals integrated in the current run
module integration_sequencer #(
   parameter int PERIOD  = 10,
   parameter int CW      = 16,
   parameter int TIMEOUT = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_start,
   input  logic          cmd_stop,
   input  logic          cmd_hold,
   input  logic [CW-1:0] run_length,
   input  logic          sample_valid,
   output logic          sample_tick,
   output logic          clear_integrator,
   output logic          start_integration,
   output logic          busy,
   output logic          done,
   output logic          fault,
   output logic [CW-1:0] sample_count
);

   localparam int PW = $clog2(PERIOD);
   localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

`ifdef INTEG_STALL_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {
      S_IDLE, S_PRIME, S_RUN, S_HOLD, S_DONE, S_FAULT
   } state_t;
   logic [SW-1:0] stall_q, stall_d;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_PRIME, S_RUN, S_HOLD, S_DONE
   } state_t;
   logic timeout_unused_s;
   assign timeout_unused_s = (TIMEOUT > 0);
`endif

   state_t        state_q, state_d;
   logic          ret_run_q, ret_run_d;   // HOLD returns to RUN (1) or PRIME (0)
   logic [PW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] count_q, count_d;
   logic          tick_q, tick_d;
   logic          clr_q, clr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          fault_q, fault_d;
   logic          en_s;

   // Next-state, period counter and registered output computation.
   always_comb begin
      state_d   = state_q;
      ret_run_d = ret_run_q;
      len_d     = len_q;
      count_d   = count_q;
      clr_d     = 1'b0;
      en_s      = 1'b0;
`ifdef INTEG_STALL_TIMEOUT_EN
      stall_d   = stall_q;
`endif
      case (state_q)
         S_PRIME, S_RUN: begin
            // stop beats hold beats tick; a tick under stop or hold is dropped
            if (cmd_stop) begin
               state_d = S_DONE;
            end else if (cmd_hold) begin
               state_d   = S_HOLD;
               ret_run_d = (state_q == S_RUN);
            end else if (tick_q) begin
               if (sample_valid) begin
`ifdef INTEG_STALL_TIMEOUT_EN
                  stall_d = {SW{1'b0}};
`endif
                  if (state_q == S_RUN) begin
                     en_s    = 1'b1;
                     count_d = count_q + CW'(1);
                     if (count_d == len_q) begin
                        state_d = S_DONE;
                     end else begin
                        state_d = S_RUN;
                     end
                  end else begin
                     // first valid strobe only loads the integrator pipeline
                     state_d = S_RUN;
                  end
               end else begin
                  state_d = state_q;
`ifdef INTEG_STALL_TIMEOUT_EN
                  stall_d = stall_q + SW'(1);
                  if (stall_d == SW'(TIMEOUT)) begin
                     state_d = S_FAULT;
                  end else begin
                     state_d = state_q;
                  end
`endif
               end
            end else begin
               state_d = state_q;
            end
         end
         S_HOLD: begin
            if (cmd_stop) begin
               state_d = S_DONE;
            end else if (!cmd_hold) begin
               state_d = ret_run_q ? S_RUN : S_PRIME;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            // IDLE, DONE and FAULT all accept a new run the same way
            if (cmd_start) begin
               count_d = {CW{1'b0}};
`ifdef INTEG_STALL_TIMEOUT_EN
               stall_d = {SW{1'b0}};
`endif
               if (run_length != {CW{1'b0}}) begin
                  len_d   = run_length;
                  clr_d   = 1'b1;
                  state_d = S_PRIME;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = state_q;
            end
         end
      endcase

      // Counter advances every clock in PRIME/RUN, freezes in HOLD, and sits
      // at 0 elsewhere so every PRIME entry from rest begins at 0.
      if ((state_q == S_PRIME) || (state_q == S_RUN)) begin
         cnt_d = (cnt_q == LAST) ? {PW{1'b0}} : cnt_q + PW'(1);
      end else if (state_q == S_HOLD) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = {PW{1'b0}};
      end

      tick_d  = ((state_d == S_PRIME) || (state_d == S_RUN)) && (cnt_d == LAST);
      busy_d  = (state_d == S_PRIME) || (state_d == S_RUN) || (state_d == S_HOLD);
      done_d  = (state_d == S_DONE);
`ifdef INTEG_STALL_TIMEOUT_EN
      fault_d = (state_d == S_FAULT);
`else
      fault_d = 1'b0;
`endif
   end

   // Sequencer state and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ret_run_q <= 1'b0;
         cnt_q     <= {PW{1'b0}};
         len_q     <= {CW{1'b0}};
         count_q   <= {CW{1'b0}};
         tick_q    <= 1'b0;
         clr_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
`ifdef INTEG_STALL_TIMEOUT_EN
         stall_q   <= {SW{1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         ret_run_q <= ret_run_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         clr_q     <= clr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fault_q   <= fault_d;
`ifdef INTEG_STALL_TIMEOUT_EN
         stall_q   <= stall_d;
`endif
      end
   end

   assign sample_tick      = tick_q;
   assign clear_integrator = clr_q;
   // Enable is the registered strobe qualified by this cycle's sample_valid,
   // so it lands in the same cycle as the strobe it belongs to.
   assign start_integration = en_s;
   assign busy             = busy_q;
   assign done             = done_q;
   assign fault            = fault_q;
   assign sample_count     = count_q;

endmodule
